// File: rtl/main_memory_ctrl_pkg.sv
// Shared configuration for the main-memory stage: geometry, FSM encoding and
// the captured-request record.
package main_memory_config;
  localparam int MAIN_MEMORY_ADDRESS_WIDTH = 32;
  localparam int MAIN_MEMORY_DATA_WIDTH    = 128;
  localparam int MAIN_MEMORY_BLOCK_SIZE    = 4;
  localparam int MAIN_MEMORY_NUM_BLOCKS    = 8;
  localparam int MAIN_MEMORY_SIZE          = MAIN_MEMORY_NUM_BLOCKS * MAIN_MEMORY_BLOCK_SIZE;

  localparam int BLOCK_W          = 8 * MAIN_MEMORY_BLOCK_SIZE;
  localparam int BLOCKS_PER_LINE  = MAIN_MEMORY_DATA_WIDTH / BLOCK_W;
  localparam int LINE_OFFSET_BITS = $clog2(MAIN_MEMORY_DATA_WIDTH / 8);
  localparam int BLOCK_INDEX_BITS = $clog2(MAIN_MEMORY_NUM_BLOCKS);
  localparam int LANE_BITS        = $clog2(BLOCKS_PER_LINE);
  localparam int LINE_IDX_BITS    = BLOCK_INDEX_BITS - LANE_BITS;
  localparam int MEM_ADDR_BITS    = $clog2(MAIN_MEMORY_SIZE);

  // Storage must hold a whole number of lines; checked at elaboration.
  localparam bit CFG_LINES_WHOLE = (MAIN_MEMORY_NUM_BLOCKS % BLOCKS_PER_LINE) == 0;

  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} mem_state_t;

  typedef struct packed {
    logic                                 write;
    logic [MAIN_MEMORY_ADDRESS_WIDTH-1:0] addr;
    logic [MAIN_MEMORY_DATA_WIDTH-1:0]    wdata;
  } mem_req_t;
endpackage

// File: rtl/main_memory_ctrl_array.sv
// Block storage: reset-initialised blocks, combinational line read, line write
// on enable, with out-of-range accesses suppressed.
module main_memory_array
  import main_memory_config::*;
(
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 en,
  input  logic                                 we,
  input  logic [MAIN_MEMORY_ADDRESS_WIDTH-1:0] addr,
  input  logic [MAIN_MEMORY_DATA_WIDTH-1:0]    wdata,
  output logic [MAIN_MEMORY_DATA_WIDTH-1:0]    rdata,
  output logic                                 oob
);
  if (!CFG_LINES_WHOLE) begin : g_cfg_bad
    $error("main_memory_array: block count is not a multiple of blocks per line");
  end

  logic [BLOCK_W-1:0]       mem_q [MAIN_MEMORY_NUM_BLOCKS];
  logic [BLOCK_W-1:0]       mem_d [MAIN_MEMORY_NUM_BLOCKS];
  logic [LINE_IDX_BITS-1:0] line_idx;
  logic                     wr_en;

  // Any set bit above the memory span is out of range; no wrap into low memory.
  assign oob      = |addr[MAIN_MEMORY_ADDRESS_WIDTH-1:MEM_ADDR_BITS];
  assign line_idx = addr[MEM_ADDR_BITS-1:LINE_OFFSET_BITS];
  assign wr_en    = en && we && !oob;

  for (genvar k = 0; k < BLOCKS_PER_LINE; k++) begin : g_lane
    assign rdata[k*BLOCK_W +: BLOCK_W] =
      (en && !oob) ? mem_q[{line_idx, LANE_BITS'(k)}] : '0;
  end

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      for (int k = 0; k < BLOCKS_PER_LINE; k++) begin
        mem_d[{line_idx, LANE_BITS'(k)}] = wdata[k*BLOCK_W +: BLOCK_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < MAIN_MEMORY_NUM_BLOCKS; b++) mem_q[b] <= BLOCK_W'(b);
    end else begin
      mem_q <= mem_d;
    end
  end
endmodule

// File: rtl/main_memory_ctrl.sv
// Main-memory controller: one request in flight, fixed access latency,
// registered response held until the consumer takes it.
module main_memory_ctrl
  import main_memory_config::*;
#(
  parameter int ACCESS_LATENCY = 4,
  parameter int ADDR_W         = MAIN_MEMORY_ADDRESS_WIDTH,
  parameter int DATA_W         = MAIN_MEMORY_DATA_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_error,
  output logic              busy
);
  localparam int CNT_W = (ACCESS_LATENCY > 1) ? $clog2(ACCESS_LATENCY) : 1;

  mem_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  mem_req_t          req_q, req_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              error_q, error_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              busy_q, busy_d;

  logic              arr_en;
  logic [DATA_W-1:0] arr_rdata;
  logic              arr_oob;

  assign arr_en = (state_q == ACCESS) && (cnt_q == '0);

  main_memory_array u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (arr_en),
    .we    (req_q.write),
    .addr  (req_q.addr),
    .wdata (req_q.wdata),
    .rdata (arr_rdata),
    .oob   (arr_oob)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    error_d = error_q;
    case (state_q)
      IDLE: if (req_valid && req_ready_q) begin
        req_d   = '{write: req_write, addr: req_addr, wdata: req_wdata};
        cnt_d   = CNT_W'(ACCESS_LATENCY - 1);
        state_d = ACCESS;
      end
      ACCESS: if (cnt_q == '0) begin
        rdata_d = req_q.write ? '0 : arr_rdata;
        error_d = arr_oob;
        state_d = RESPOND;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
      RESPOND: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Handshake outputs are registered copies of the next-state decode.
    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == RESPOND);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_q        <= '0;
      rdata_q      <= '0;
      error_q      <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      rdata_q      <= rdata_d;
      error_q      <= error_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_error = error_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_main_memory_ctrl.sv
// Scoreboard bench: two controllers (latency 4 and latency 1); the driver queues
// expected responses, a monitor checks latency, stability and data.
module tb_main_memory_ctrl;
  typedef struct {
    logic [127:0] d;
    logic         e;
    longint       cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid [2];
  logic         req_ready [2];
  logic         req_write [2];
  logic [31:0]  req_addr  [2];
  logic [127:0] req_wdata [2];
  logic         resp_valid[2];
  logic         resp_ready[2];
  logic [127:0] resp_rdata[2];
  logic         resp_error[2];
  logic         busy      [2];

  int     nchk = 0;
  int     nerr = 0;
  longint cyc  = 0;
  exp_t   q0[$];
  exp_t   q1[$];
  longint lasths[2];
  logic   vprev[2];
  logic   rprev[2];
  logic [127:0] dprev[2];
  logic   eprev[2];
  localparam int LAT [2] = '{4, 1};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  main_memory_ctrl #(.ACCESS_LATENCY(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_error(resp_error[0]), .busy(busy[0]));

  main_memory_ctrl #(.ACCESS_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_error(resp_error[1]), .busy(busy[1]));

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int qsz(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t qfront(input int i);
    return (i == 0) ? q0[0] : q1[0];
  endfunction

  task automatic qpop(input int i);
    if (i == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endtask

  task automatic qpush(input int i, input exp_t e);
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Monitor: latency on each new response, stability under backpressure, data at handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      for (int i = 0; i < 2; i++) begin vprev[i] = 1'b0; rprev[i] = 1'b0; end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (resp_valid[i] && !vprev[i]) begin
          if (qsz(i) == 0) begin
            nchk++; nerr++;
            $display("FAIL unexpected_resp dut%0d: got resp_valid=1 expected none", i);
          end else begin
            chk($sformatf("latency dut%0d", i), 128'(cyc), 128'(qfront(i).cyc));
          end
        end
        if (resp_valid[i] && vprev[i] && !rprev[i]) begin
          chk($sformatf("stable_rdata dut%0d", i), resp_rdata[i], dprev[i]);
          chk($sformatf("stable_error dut%0d", i), 128'(resp_error[i]), 128'(eprev[i]));
        end
        if (resp_valid[i] && resp_ready[i] && qsz(i) != 0) begin
          chk($sformatf("rdata dut%0d", i), resp_rdata[i], qfront(i).d);
          chk($sformatf("error dut%0d", i), 128'(resp_error[i]), 128'(qfront(i).e));
          qpop(i);
          lasths[i] = cyc + 1;
        end
        vprev[i] = resp_valid[i];
        rprev[i] = resp_ready[i];
        dprev[i] = resp_rdata[i];
        eprev[i] = resp_error[i];
      end
    end
  end

  task automatic do_req(input int i, input logic wr, input logic [31:0] a,
                        input logic [127:0] wd, input logic [127:0] ed, input logic ee,
                        input bit push, output longint hs);
    int n;
    exp_t e;
    @(negedge clk);
    req_valid[i] = 1'b1;
    req_write[i] = wr;
    req_addr[i]  = a;
    req_wdata[i] = wd;
    n = 0;
    while (!req_ready[i] && n < 100) begin @(negedge clk); n++; end
    if (!req_ready[i]) begin
      nchk++; nerr++;
      $display("FAIL req_accept_timeout dut%0d: got req_ready=0 expected 1", i);
      req_valid[i] = 1'b0;
      hs = -1;
      return;
    end
    @(posedge clk);
    #1;
    hs = cyc;
    if (push) begin
      e.d = ed; e.e = ee; e.cyc = hs + LAT[i];
      qpush(i, e);
    end
    // Scramble fields after the handshake; the controller must ignore them.
    req_valid[i] = 1'b0;
    req_write[i] = ~wr;
    req_addr[i]  = 32'h0000_0010 ^ a;
    req_wdata[i] = ~wd;
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() + q1.size()) != 0 && n < 100) begin @(negedge clk); n++; end
    if ((q0.size() + q1.size()) != 0) begin
      nchk++; nerr++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q0.size() + q1.size());
    end
  endtask

  localparam logic [127:0] INIT0 = 128'h00000003_00000002_00000001_00000000;
  localparam logic [127:0] INIT1 = 128'h00000007_00000006_00000005_00000004;
  localparam logic [127:0] WPAT  = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;

  initial begin
    longint hs, hs2;
    int n;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_write[i] = 1'b0; req_addr[i] = '0; req_wdata[i] = '0;
      resp_ready[i] = 1'b1; lasths[i] = 0;
    end
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 128'(req_ready[0]), 128'(1));
    chk("rst_resp_valid", 128'(resp_valid[0]), 128'(0));
    chk("rst_busy", 128'(busy[0]), 128'(0));
    chk("rst_rdata", resp_rdata[0], 128'h0);
    chk("rst_error", 128'(resp_error[0]), 128'(0));
    rst_n = 1'b1;

    // Basic read, write, aligned-down read-back.
    do_req(0, 1'b0, 32'h00, '0, INIT0, 1'b0, 1, hs);
    drain();
    do_req(0, 1'b1, 32'h10, WPAT, 128'h0, 1'b0, 1, hs);
    drain();
    do_req(0, 1'b0, 32'h13, '0, WPAT, 1'b0, 1, hs);
    drain();

    // Out of range: no data, no write, no wrap into line 1.
    do_req(0, 1'b0, 32'h20, '0, 128'h0, 1'b1, 1, hs);
    drain();
    do_req(0, 1'b1, 32'hFFFF_FFF0, ~WPAT, 128'h0, 1'b1, 1, hs);
    drain();
    do_req(0, 1'b0, 32'h00, '0, INIT0, 1'b0, 1, hs);
    drain();
    do_req(0, 1'b0, 32'h10, '0, WPAT, 1'b0, 1, hs);
    drain();

    // Backpressure with a second request waiting.
    resp_ready[0] = 1'b0;
    do_req(0, 1'b0, 32'h00, '0, INIT0, 1'b0, 1, hs);
    fork
      do_req(0, 1'b0, 32'h10, '0, WPAT, 1'b0, 1, hs2);
      begin
        n = 0;
        while (!resp_valid[0] && n < 50) begin @(negedge clk); n++; end
        chk("bp_resp_valid", 128'(resp_valid[0]), 128'(1));
        repeat (10) begin
          @(negedge clk);
          chk("bp_req_ready", 128'(req_ready[0]), 128'(0));
        end
        @(posedge clk);
        #1 resp_ready[0] = 1'b1;
      end
    join
    chk("bp_accept_after_resp", 128'(hs2), 128'(lasths[0] + 1));
    drain();

    // Reset during ACCESS of a write: no response, write lost, init restored.
    do_req(0, 1'b1, 32'h10, ~WPAT, 128'h0, 1'b0, 0, hs);
    @(negedge clk);
    chk("mid_busy", 128'(busy[0]), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_resp_valid", 128'(resp_valid[0]), 128'(0));
    chk("mid_rst_busy", 128'(busy[0]), 128'(0));
    chk("mid_rst_req_ready", 128'(req_ready[0]), 128'(1));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("mid_no_resp", 128'(resp_valid[0]), 128'(0));
    do_req(0, 1'b0, 32'h10, '0, INIT1, 1'b0, 1, hs);
    drain();

    // Latency-1 instance, back-to-back reads.
    do_req(1, 1'b0, 32'h00, '0, INIT0, 1'b0, 1, hs);
    do_req(1, 1'b0, 32'h10, '0, INIT1, 1'b0, 1, hs);
    drain();

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
